// File: rtl/floppy_pkg.sv
// Shared types and constants for the floppy track cache: FSM states, sector
// geometry and the track-to-LBA mapping used by both transfer phases.
package floppy_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      LOAD  = 2'd2
   } state_e;

   localparam int SECTOR_BYTES          = 512;
   localparam int DEF_SECTORS_PER_TRACK = 13;

   // Track images are packed back to back in the SD image with no base offset.
   function automatic logic [31:0] track_lba(input logic [31:0] trk, input logic [31:0] spt);
      return trk * spt;
   endfunction

endpackage

// File: rtl/sd_sector_seq.sv
// Per-sector hps_io handshake: presents a request and LBA, steps through
// count sectors on sd_ack edges and pulses done on the final ack fall.
module sd_sector_seq
   import floppy_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_write,
   input  logic [31:0] first_lba,
   input  logic [4:0]  count,
   input  logic        sd_ack,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [3:0]  track_sec,
   output logic        done
);

   logic [31:0] lba_q, lba_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [3:0]  sec_q, sec_d;
   logic        active_q, active_d;
   logic        old_ack_q, old_ack_d;

   logic ack_rise, ack_fall, req, last_sec;

   always_comb begin
      ack_rise = sd_ack & ~old_ack_q;
      ack_fall = ~sd_ack & old_ack_q;
      req      = rd_q | wr_q;
      last_sec = ({1'b0, sec_q} == (count - 5'd1));
      done     = active_q & ack_fall & ~req;

      lba_d     = lba_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      sec_d     = sec_q;
      active_d  = active_q;
      old_ack_d = sd_ack;

      // A start on the same edge as the previous phase's final fall wins,
      // which lets a flush chain straight into the following load.
      if (start) begin
         lba_d    = first_lba;
         rd_d     = ~is_write;
         wr_d     = is_write;
         sec_d    = 4'd0;
         active_d = 1'b1;
      end else if (active_q) begin
         if (ack_rise && req) begin
            lba_d = lba_q + 32'd1;
            if (last_sec) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
            end
         end
         if (ack_fall) begin
            sec_d = sec_q + 4'd1;
            if (!req) active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lba_q     <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         sec_q     <= '0;
         active_q  <= 1'b0;
         old_ack_q <= 1'b0;
      end else begin
         lba_q     <= lba_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         sec_q     <= sec_d;
         active_q  <= active_d;
         old_ack_q <= old_ack_d;
      end
   end

   assign sd_lba    = lba_q;
   assign sd_rd     = rd_q;
   assign sd_wr     = wr_q;
   assign track_sec = sec_q;

endmodule

// File: rtl/floppy_track_cache.sv
// Multi-drive track cache: loads the head's track from the SD image, writing a
// modified track back first, and stalls the CPU while either transfer runs.
module floppy_track_cache
   import floppy_pkg::*;
#(
   parameter int NUM_DRIVES        = 2,
   parameter int SECTORS_PER_TRACK = DEF_SECTORS_PER_TRACK,
   parameter int TRACK_BITS        = 6,
   parameter int DW                = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [DW-1:0]         drive_sel,
   input  logic [TRACK_BITS-1:0] track,
   input  logic                  track_dirty,
   input  logic [NUM_DRIVES-1:0] img_mounted,
   input  logic [NUM_DRIVES-1:0] img_valid,
   output logic [31:0]           sd_lba,
   output logic                  sd_rd,
   output logic                  sd_wr,
   output logic [DW-1:0]         sd_drive,
   input  logic                  sd_ack,
   output logic [3:0]            track_sec,
   output logic                  cpu_wait,
   output logic                  busy
);

   state_e                  state_q, state_d;
   logic [DW-1:0]           cur_drive_q, cur_drive_d;
   logic [TRACK_BITS-1:0]   cur_track_q, cur_track_d;
   logic                    dirty_q, dirty_d;
   logic [NUM_DRIVES-1:0]   mount_pend_q, mount_pend_d;
   logic [DW-1:0]           sd_drive_q, sd_drive_d;
   logic                    cpu_wait_q, cpu_wait_d;

   logic        seq_start, seq_write, seq_done;
   logic [31:0] seq_lba;
   logic        do_load, dirty_eff;

   always_comb begin
      state_d      = state_q;
      cur_drive_d  = cur_drive_q;
      cur_track_d  = cur_track_q;
      dirty_d      = dirty_q;
      mount_pend_d = mount_pend_q | img_mounted;
      sd_drive_d   = sd_drive_q;
      cpu_wait_d   = cpu_wait_q;
      seq_start    = 1'b0;
      seq_write    = 1'b0;
      seq_lba      = '0;
      do_load      = 1'b0;
      // A write pulse coinciding with a head move still counts for the flush.
      dirty_eff    = dirty_q | track_dirty;

      case (state_q)
         IDLE: begin
            dirty_d = dirty_eff;
            if ((drive_sel != cur_drive_q) || (track != cur_track_q)) begin
               if (dirty_eff && img_valid[cur_drive_q]) begin
                  state_d    = FLUSH;
                  seq_start  = 1'b1;
                  seq_write  = 1'b1;
                  seq_lba    = track_lba(32'(cur_track_q), 32'(SECTORS_PER_TRACK));
                  sd_drive_d = cur_drive_q;
                  cpu_wait_d = 1'b1;
               end else begin
                  do_load = 1'b1;
               end
            end else if (mount_pend_q[cur_drive_q] && !img_mounted[cur_drive_q]) begin
               // The old image is gone; its buffered edits are discarded.
               do_load = 1'b1;
            end
         end
         FLUSH: begin
            if (seq_done) do_load = 1'b1;
         end
         LOAD: begin
            if (seq_done) begin
               state_d    = IDLE;
               cpu_wait_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         cur_drive_d             = drive_sel;
         cur_track_d             = track;
         dirty_d                 = 1'b0;
         mount_pend_d[drive_sel] = 1'b0;
         if (img_valid[drive_sel]) begin
            state_d    = LOAD;
            seq_start  = 1'b1;
            seq_write  = 1'b0;
            seq_lba    = track_lba(32'(track), 32'(SECTORS_PER_TRACK));
            sd_drive_d = drive_sel;
            cpu_wait_d = 1'b1;
         end else begin
            state_d    = IDLE;
            cpu_wait_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cur_drive_q  <= '0;
         cur_track_q  <= '0;
         dirty_q      <= 1'b0;
         mount_pend_q <= '0;
         sd_drive_q   <= '0;
         cpu_wait_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_drive_q  <= cur_drive_d;
         cur_track_q  <= cur_track_d;
         dirty_q      <= dirty_d;
         mount_pend_q <= mount_pend_d;
         sd_drive_q   <= sd_drive_d;
         cpu_wait_q   <= cpu_wait_d;
      end
   end

   sd_sector_seq u_seq (
      .clk       (clk_sys),
      .rst_n     (reset_n),
      .start     (seq_start),
      .is_write  (seq_write),
      .first_lba (seq_lba),
      .count     (5'(SECTORS_PER_TRACK)),
      .sd_ack    (sd_ack),
      .sd_lba    (sd_lba),
      .sd_rd     (sd_rd),
      .sd_wr     (sd_wr),
      .track_sec (track_sec),
      .done      (seq_done)
   );

   assign sd_drive = sd_drive_q;
   assign cpu_wait = cpu_wait_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_floppy_track_cache.sv
// Directed bench for floppy_track_cache: an hps_io responder checks every
// sector request against a track-level model of flushes and loads.
module tb_floppy_track_cache;

   localparam int SPT = 13;
   localparam int W   = 41;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [0:0]  drive_sel;
   logic [5:0]  track;
   logic        track_dirty;
   logic [1:0]  img_mounted;
   logic [1:0]  img_valid;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr;
   logic [0:0]  sd_drive;
   logic        sd_ack;
   logic [3:0]  track_sec;
   logic        cpu_wait, busy;

   floppy_track_cache dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .drive_sel   (drive_sel),
      .track       (track),
      .track_dirty (track_dirty),
      .img_mounted (img_mounted),
      .img_valid   (img_valid),
      .sd_lba      (sd_lba),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_drive    (sd_drive),
      .sd_ack      (sd_ack),
      .track_sec   (track_sec),
      .cpu_wait    (cpu_wait),
      .busy        (busy)
   );

   // clock / reset
   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // scoreboard
   logic [W-1:0] exp_q[$];
   logic [W-1:0] log_q[$];
   int total = 0;
   int bad   = 0;
   int rise_cnt = 0;
   int fall_cyc = 0;
   int idle_cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // track-level model
   int   m_drive = 0;
   int   m_track = 0;
   logic m_dirty = 1'b0;

   task automatic push_phase(input logic wr, input int d, input int t);
      for (int s = 0; s < SPT; s++)
         exp_q.push_back({wr, 4'(d), 4'(s), 32'(SPT * t + s)});
   endtask

   task automatic model_change(input int nd, input int nt);
      if (nd != m_drive || nt != m_track) begin
         if (m_dirty && img_valid[m_drive]) push_phase(1'b1, m_drive, m_track);
         m_dirty = 1'b0;
         m_drive = nd;
         m_track = nt;
         if (img_valid[nd]) push_phase(1'b0, nd, nt);
      end
   endtask

   // hps_io responder and per-sector compare
   initial begin
      logic [W-1:0] cap;
      sd_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (reset_n && (sd_rd || sd_wr)) begin
            cap = {sd_wr, 4'(sd_drive), track_sec, sd_lba};
            log_q.push_back(cap);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_req actual=%0h expected=none", cap);
            end else begin
               chk("sector", cap, exp_q.pop_front());
            end
            sd_ack = 1'b1;
            rise_cnt++;
            repeat (3) @(negedge clk_sys);
            sd_ack = 1'b0;
            fall_cyc = cyc;
         end
      end
   end

   // per-cycle invariants
   always @(negedge clk_sys) begin
      if (reset_n) begin
         chk("rd_wr_both", sd_rd & sd_wr, 0);
         chk("req_unstalled", (sd_rd | sd_wr) & ~cpu_wait, 0);
      end
   end

   // driver tasks
   task automatic wait_idle(input string name);
      int n = 0;
      @(posedge clk_sys); #1;
      while ((busy || exp_q.size() != 0) && n < 2000) begin
         @(posedge clk_sys); #1;
         n++;
      end
      idle_cyc = cyc;
      chk({name, "_timeout"}, n < 2000, 1);
      chk({name, "_left"}, exp_q.size(), 0);
      chk({name, "_wait"}, cpu_wait, 0);
   endtask

   task automatic quiet(input string name, input int n);
      logic any = 1'b0;
      repeat (n) begin
         @(posedge clk_sys); #1;
         if (busy || cpu_wait || sd_rd || sd_wr) any = 1'b1;
      end
      chk(name, any, 0);
   endtask

   task automatic pulse_dirty();
      @(negedge clk_sys); track_dirty = 1'b1;
      @(negedge clk_sys); track_dirty = 1'b0;
      m_dirty = 1'b1;
   endtask

   initial begin
      int base, n;
      reset_n = 1'b0; drive_sel = '0; track = '0; track_dirty = 1'b0;
      img_mounted = '0; img_valid = 2'b11;
      #12;
      chk("rst_lba", sd_lba, 0);
      chk("rst_rd", sd_rd, 0);
      chk("rst_wr", sd_wr, 0);
      chk("rst_drive", sd_drive, 0);
      chk("rst_sec", track_sec, 0);
      chk("rst_wait", cpu_wait, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk_sys); reset_n = 1'b1;
      quiet("idle_after_reset", 5);

      // clean change 0 -> 5
      @(negedge clk_sys); track = 6'd5; model_change(0, 5);
      wait_idle("t1");
      chk("t1_drop_cycle", idle_cyc - fall_cyc, 1);
      chk("t1_count", log_q.size(), 13);
      chk("t1_first", log_q[0], {1'b0, 4'd0, 4'd0, 32'd65});
      chk("t1_last", log_q[12], {1'b0, 4'd0, 4'd12, 32'd77});

      // dirty change 5 -> 6
      pulse_dirty();
      @(negedge clk_sys); track = 6'd6; model_change(0, 6);
      wait_idle("t2");
      chk("t2_count", log_q.size(), 39);
      chk("t2_first_wr", log_q[13], {1'b1, 4'd0, 4'd0, 32'd65});
      chk("t2_first_rd", log_q[26], {1'b0, 4'd0, 4'd0, 32'd78});
      chk("t2_last_rd", log_q[38], {1'b0, 4'd0, 4'd12, 32'd90});
      quiet("t2_clean", 10);

      // remount with dirty data: reload without write-back
      pulse_dirty();
      @(negedge clk_sys); img_mounted = 2'b01;
      m_dirty = 1'b0; push_phase(1'b0, 0, 6);
      repeat (3) @(negedge clk_sys);
      img_mounted = 2'b00;
      wait_idle("t3");
      chk("t3_count", log_q.size(), 52);
      quiet("t3_pend_cleared", 20);

      // drive switch with dirty track
      pulse_dirty();
      @(negedge clk_sys); drive_sel = 1'b1; track = 6'd3; model_change(1, 3);
      wait_idle("t4");
      chk("t4_flush_first", log_q[52], {1'b1, 4'd0, 4'd0, 32'd78});
      chk("t4_load_first", log_q[65], {1'b0, 4'd1, 4'd0, 32'd39});
      quiet("t4_settled", 10);

      // switch to an empty slot
      @(negedge clk_sys); drive_sel = 1'b0; model_change(0, 3);
      wait_idle("t5a");
      @(negedge clk_sys); img_valid = 2'b01; drive_sel = 1'b1; model_change(1, 3);
      quiet("t5_no_req", 10);
      @(negedge clk_sys); img_valid = 2'b11;
      quiet("t5_cur_drive_latched", 10);

      // reset in the middle of a load
      @(negedge clk_sys); drive_sel = 1'b0; track = 6'd10; model_change(0, 10);
      base = rise_cnt; n = 0;
      while (rise_cnt < base + 4 && n < 500) begin
         @(posedge clk_sys);
         n++;
      end
      chk("t6_reach_rise4", n < 500, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_lba", sd_lba, 0);
      chk("t6_rd", sd_rd, 0);
      chk("t6_wr", sd_wr, 0);
      chk("t6_drive", sd_drive, 0);
      chk("t6_sec", track_sec, 0);
      chk("t6_wait", cpu_wait, 0);
      chk("t6_busy", busy, 0);
      exp_q.delete();
      m_drive = 0; m_track = 0; m_dirty = 1'b0;
      drive_sel = 1'b0; track = 6'd0;
      repeat (6) @(negedge clk_sys);
      reset_n = 1'b1;
      @(posedge clk_sys); #1;
      chk("t6_post_busy", busy, 0);
      chk("t6_post_sec", track_sec, 0);
      quiet("t6_post_quiet", 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
